// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, status register bit map and register addresses.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Bit positions inside the status register
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  // Two-address register map
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // Assemble the status byte; upper nibble always reads zero
  function automatic logic [7:0] status_byte(input logic ovf, input logic empty,
                                             input logic full, input logic busy);
    logic [7:0] s;
    s           = 8'h00;
    s[ST_OVF]   = ovf;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_BUSY]  = busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Two-address CPU bus shared by the UART blocks: strobe, write enable, address, write and read data.
interface uart_tx_fifo_ctrl_if;
  logic [7:0] i_dat;
  logic [7:0] o_dat;
  logic       i_addr;
  logic       i_we;
  logic       i_cyc;

  modport master (output i_dat, output i_addr, output i_we, output i_cyc, input o_dat);
  modport slave  (input i_dat, input i_addr, input i_we, input i_cyc, output o_dat);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small first-word-fall-through byte FIFO: the head is always visible on dout_o so a pop
// can load it into the shifter on the same edge. Push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [7:0]             din_i,
  output logic [7:0]             dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop frees the slot this cycle, so a push on a full FIFO still fits
  assign push_ok = push_i & (~full_o | pop_ok);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy only moves when exactly one of push/pop takes effect
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmitter (8N1, LSB first) behind the two-address bus: bytes written to address 0
// queue in a FIFO and are shifted out at CLKS_PER_BIT clocks per bit; address 1 reads status.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int SYS_CLK      = 50_000_000,
  parameter int BAUDRATE     = 115200,
  parameter int CLKS_PER_BIT = SYS_CLK / BAUDRATE,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  uart_tx_fifo_ctrl_if.slave  bus,
  output logic                tx,
  output logic                o_int
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             int_q;
  logic             ovf_q;

  logic             push_req;
  logic             stat_rd;
  logic             bit_end;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;

  assign push_req = bus.i_cyc & bus.i_we & (bus.i_addr == ADDR_DATA);
  assign stat_rd  = bus.i_cyc & ~bus.i_we & (bus.i_addr == ADDR_STATUS);
  assign bit_end  = (baud_q == LAST_CNT);
  // The FIFO head is taken when the line is idle, or at the last clock of a stop bit
  // so that queued frames follow each other without an idle gap
  assign pop      = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (bus.i_dat),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Read data is purely a function of the address; only the status address returns data
  assign bus.o_dat = (bus.i_addr == ADDR_STATUS)
                   ? status_byte(ovf_q, fifo_count == '0, fifo_count == FCW'(FIFO_DEPTH),
                                 state_q != IDLE)
                   : 8'h00;

  assign tx    = tx_q;
  assign o_int = int_q;

  // Sticky overflow: set by a dropped push, cleared by a status read (which still sees it)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      ovf_q <= 1'b1;
    end else if (stat_rd) begin
      ovf_q <= 1'b0;
    end
  end

  // Transmit FSM with baud counter and shifter; tx is registered from the current state,
  // so the line follows the state by one clock
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      int_q     <= 1'b0;
    end else begin
      int_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            baud_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (bit_end) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_dout;
              state_q <= START;
            end else begin
              state_q <= IDLE;
              int_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: frame-timer reference model checked every cycle, a line
// receiver that decodes transmitted bytes, directed scenarios and randomized bus traffic.
module tb_uart_tx_fifo_ctrl;

  localparam int C     = 8;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic o_int;

  int checks  = 0;
  int passes  = 0;
  int cyc     = 0;
  int int_cnt = 0;
  int int_cyc = 0;

  uart_tx_fifo_ctrl_if bus_if ();

  uart_tx_fifo_ctrl #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_if),
    .tx      (tx),
    .o_int   (o_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Transmitter seen as "a frame in progress, m_t clocks since it was taken from the queue".
  byte unsigned mq[$];
  bit           m_busy = 0;
  int           m_t    = 0;
  logic [7:0]   m_cur  = 8'h00;
  bit           m_ovf  = 0;
  logic         m_tx   = 1'b1;
  logic         m_int  = 1'b0;
  bit           model_ok = 0;

  // Line level for bit slot idx of a frame: start, 8 data bits LSB first, stop
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit push;
    bit rd;
    bit pop;
    if (rst) begin
      mq.delete();
      m_busy = 0; m_t = 0; m_ovf = 0; m_tx = 1'b1; m_int = 1'b0;
      model_ok = 1;
    end else begin
      push  = bus_if.i_cyc && bus_if.i_we && !bus_if.i_addr;
      rd    = bus_if.i_cyc && !bus_if.i_we && bus_if.i_addr;
      m_tx  = m_busy ? frame_bit(m_cur, m_t / C) : 1'b1;
      m_int = m_busy && (m_t == FRAME - 1) && (mq.size() == 0);
      pop   = (mq.size() != 0) && (!m_busy || m_t == FRAME - 1);
      if (m_busy) begin
        if (m_t == FRAME - 1) m_busy = 0;
        else m_t++;
      end
      if (pop) begin
        m_cur = mq.pop_front(); m_busy = 1; m_t = 0;
      end
      if (push) begin
        if (mq.size() < D) mq.push_back(bus_if.i_dat);
        else m_ovf = 1;
      end
      if (rd) m_ovf = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ok) begin
      logic [7:0] st;
      st = {4'd0, m_ovf, mq.size() == 0, mq.size() == D, m_busy};
      chk("tx", tx, m_tx);
      chk("o_int", o_int, m_int);
      chk("o_dat", bus_if.o_dat, bus_if.i_addr ? st : 8'h00);
    end
  end

  // Interrupt monitor
  always @(negedge clk) begin
    if (o_int === 1'b1) begin
      int_cnt++;
      int_cyc = cyc;
    end
  end

  // ---------------- line receiver ----------------
  byte unsigned rxq[$];
  byte unsigned exp_q[$];
  bit           rx_busy = 0;
  int           rx_cnt  = 0;
  logic [7:0]   rx_sh   = 8'h00;
  logic         tx_prev = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (tx_prev === 1'b1 && tx === 1'b0) begin
        rx_busy = 1; rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= C && rx_cnt < 9 * C && (rx_cnt % C) == C / 2) rx_sh[rx_cnt / C - 1] = tx;
      if (rx_cnt == 9 * C + C / 2) begin
        chk("rx_stop_bit", tx, 1'b1);
        rxq.push_back(rx_sh);
        rx_busy = 0;
      end
    end
    tx_prev = tx;
  end

  task automatic chk_rx(input string name);
    logic [31:0] v;
    chk({name, "_rx_count"}, rxq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      v = 'x;
      if (i < rxq.size()) v = {24'd0, rxq[i]};
      chk($sformatf("%s_rx_byte%0d", name, i), v, {24'd0, exp_q[i]});
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic c, input logic w, input logic a, input logic [7:0] d);
    @(posedge clk); #1;
    bus_if.i_cyc = c; bus_if.i_we = w; bus_if.i_addr = a; bus_if.i_dat = d;
  endtask

  task automatic wait_int(input int n0, input int bound, input string name);
    int k;
    k = 0;
    while (int_cnt == n0 && k < bound) begin
      @(negedge clk); k++;
    end
    if (int_cnt == n0) begin
      checks++;
      $display("FAIL %s_timeout: no o_int within %0d cycles", name, bound);
    end
    repeat (4) @(posedge clk);
  endtask

  int bits_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int wp[5]      = '{30, 2, 10, 1, 50};

  initial begin
    int n0;
    int c0;
    int k;
    bus_if.i_cyc = 1'b0; bus_if.i_we = 1'b0; bus_if.i_addr = 1'b1; bus_if.i_dat = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_int", o_int, 1'b0);
    chk("reset_status", bus_if.o_dat, 8'h04);
    @(posedge clk); #1; rst = 1'b0;

    // Single byte A5: latency, bit pattern, interrupt, final status
    rxq.delete(); n0 = int_cnt;
    drive(1, 1, 0, 8'hA5); drive(0, 0, 0, 8'h00); c0 = cyc;
    @(posedge clk); #1; chk("a5_tx_E1", tx, 1'b1);
    @(posedge clk); #1; chk("a5_tx_E2", tx, 1'b0);
    repeat (C / 2) @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      repeat (C) @(posedge clk); #1;
      chk($sformatf("a5_bit%0d", b), tx, bits_a5[b][0]);
    end
    repeat (C) @(posedge clk); #1; chk("a5_stop", tx, 1'b1);
    wait_int(n0, 4 * FRAME, "a5");
    chk("a5_int_latency", int_cyc - c0, FRAME + 1);
    chk("a5_int_count", int_cnt - n0, 1);
    exp_q = '{8'hA5}; chk_rx("a5");
    drive(1, 0, 1, 8'h00); @(negedge clk); chk("a5_status", bus_if.o_dat, 8'h04);
    drive(0, 0, 0, 8'h00);

    // Back-to-back frames
    rxq.delete(); n0 = int_cnt;
    drive(1, 1, 0, 8'h00); drive(1, 1, 0, 8'hFF); drive(1, 1, 0, 8'h3C); drive(0, 0, 0, 8'h00);
    c0 = cyc - 2;
    wait_int(n0, 6 * FRAME, "b2b");
    chk("b2b_int_latency", int_cyc - c0, 3 * FRAME + 1);
    chk("b2b_int_count", int_cnt - n0, 1);
    exp_q = '{8'h00, 8'hFF, 8'h3C}; chk_rx("b2b");

    // Overflow: six writes in a row, depth four
    rxq.delete(); n0 = int_cnt;
    drive(1, 1, 0, 8'h11); drive(1, 1, 0, 8'h22); drive(1, 1, 0, 8'h33);
    drive(1, 1, 0, 8'h44); drive(1, 1, 0, 8'h55); drive(1, 1, 0, 8'h66);
    drive(1, 0, 1, 8'h00); @(negedge clk); chk("ovf_status1", bus_if.o_dat, 8'h0B);
    drive(1, 0, 1, 8'h00); @(negedge clk); chk("ovf_status2", bus_if.o_dat, 8'h03);
    drive(0, 0, 0, 8'h00);
    wait_int(n0, 7 * FRAME, "ovf");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}; chk_rx("ovf");

    // Push on a full FIFO at the same edge the stop bit pops
    rxq.delete(); n0 = int_cnt;
    drive(1, 1, 0, 8'hA1); drive(1, 1, 0, 8'hA2); drive(1, 1, 0, 8'hA3);
    drive(1, 1, 0, 8'hA4); drive(1, 1, 0, 8'hA5); drive(0, 0, 0, 8'h00);
    repeat (74) @(posedge clk);
    drive(1, 0, 1, 8'h00); @(negedge clk); chk("simul_pre_status", bus_if.o_dat, 8'h03);
    drive(1, 1, 0, 8'hA6);
    drive(1, 0, 1, 8'h00); @(negedge clk); chk("simul_post_status", bus_if.o_dat, 8'h03);
    drive(0, 0, 0, 8'h00);
    wait_int(n0, 8 * FRAME, "simul");
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6}; chk_rx("simul");

    // Reset during data bit 3
    rxq.delete(); n0 = int_cnt;
    drive(1, 1, 0, 8'h5A); drive(0, 0, 0, 8'h00);
    repeat (34) @(posedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_tx", tx, 1'b1);
    repeat (2 * FRAME) @(posedge clk);
    chk("rst_no_int", int_cnt - n0, 0);
    drive(1, 0, 1, 8'h00); @(negedge clk); chk("rst_status", bus_if.o_dat, 8'h04);
    rxq.delete(); n0 = int_cnt;
    drive(1, 1, 0, 8'h81); drive(0, 0, 0, 8'h00);
    wait_int(n0, 4 * FRAME, "rst81");
    exp_q = '{8'h81}; chk_rx("rst81");

    // Bus isolation during a frame
    rxq.delete(); n0 = int_cnt;
    drive(1, 1, 0, 8'h96);
    for (int i = 0; i < 30; i++) begin
      drive(1, 1, 1, 8'($urandom));
      drive(1, 0, 0, 8'h00); @(negedge clk);
      chk("iso_addr0", bus_if.o_dat, 8'h00);
    end
    drive(1, 0, 1, 8'h00); @(negedge clk); chk("iso_status", bus_if.o_dat, 8'h05);
    drive(0, 0, 0, 8'h00);
    wait_int(n0, 4 * FRAME, "iso");
    exp_q = '{8'h96}; chk_rx("iso");

    // Randomized traffic with occasional resets, checked by the model every cycle
    for (int blk = 0; blk < 5; blk++) begin
      for (int n = 0; n < 600; n++) begin
        int r;
        r = $urandom_range(0, 99);
        @(posedge clk); #1;
        rst = ($urandom_range(0, 499) == 0);
        bus_if.i_dat = 8'($urandom);
        if (r < wp[blk]) begin
          bus_if.i_cyc = 1'b1; bus_if.i_we = 1'b1; bus_if.i_addr = 1'b0;
        end else if (r < wp[blk] + 10) begin
          bus_if.i_cyc = 1'b1; bus_if.i_we = 1'b1; bus_if.i_addr = 1'b1;
        end else if (r < wp[blk] + 25) begin
          bus_if.i_cyc = 1'b1; bus_if.i_we = 1'b0; bus_if.i_addr = 1'b1;
        end else if (r < wp[blk] + 35) begin
          bus_if.i_cyc = 1'b1; bus_if.i_we = 1'b0; bus_if.i_addr = 1'b0;
        end else begin
          bus_if.i_cyc = 1'b0;
          bus_if.i_we = 1'($urandom_range(0, 1));
          bus_if.i_addr = 1'($urandom_range(0, 1));
        end
      end
    end
    @(posedge clk); #1; rst = 1'b0;
    bus_if.i_cyc = 1'b0; bus_if.i_we = 1'b0; bus_if.i_addr = 1'b0;
    k = 0;
    while ((m_busy || mq.size() != 0) && k < 20 * FRAME) begin
      @(posedge clk); k++;
    end
    repeat (4) @(posedge clk);
    drive(1, 0, 1, 8'h00); @(negedge clk);
    chk("final_status", bus_if.o_dat & 8'h07, 8'h04);
    drive(0, 0, 0, 8'h00);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
